fifo_stream_reader: RTL and testbench
=====================================

# fifo_stream_reader

Drains 8-bit pixel samples from the image FIFO into a valid/ready pixel stream for the downstream 2D filter stages. It issues single-cycle pop requests to the FIFO and absorbs the FIFO's one-cycle read latency with a 2-entry skid buffer. It annotates every pixel with its column/row position and with frame/line markers. It sits directly downstream of the FIFO's pop side, in the FIFO's pop clock domain.

## Interface
- DATA_WIDTH, 8, pixel width; must match the FIFO data width
- IMAGE_WIDTH, 640, pixels per line
- IMAGE_HEIGHT, 480, lines per frame
- COUNTER_WIDTH, 16, width of the column/row counters

- clock  in  1  pop-domain clock, rising edge
- reset  in  1  asynchronous, active-low reset
- enable  in  1  run request; low stops new pops and drains the buffer
- fifo_ready  in  1  FIFO holds at least one sample
- fifo_data  in  DATA_WIDTH  FIFO output, valid the cycle after fifo_pop
- fifo_popped_last  in  1  the previous pop removed the final FIFO entry
- fifo_pop  out  1  one-cycle pop request
- pixel_data  out  DATA_WIDTH  head of the skid buffer
- pixel_valid  out  1  pixel_data valid
- pixel_ready  in  1  downstream accepts; a transfer occurs when valid and ready are both high
- column  out  COUNTER_WIDTH  column of the current pixel_data
- row  out  COUNTER_WIDTH  row of the current pixel_data
- start_of_frame  out  1  current pixel is (0,0)
- end_of_line  out  1  column == IMAGE_WIDTH-1
- end_of_frame  out  1  last pixel of the frame
- frame_done  out  1  one-cycle pulse after the last pixel of the frame transfers

## Operation
- FSM states: IDLE, RUN, DRAIN.
  - IDLE -> RUN when enable = 1.
  - RUN -> DRAIN when enable = 0.
  - DRAIN -> IDLE when occupancy = 0 and no pop is in flight.
  - DRAIN -> RUN if enable returns to 1.
- Credits: occupancy (0..2) plus in_flight (0..1) never exceeds 2.
- Pop rule: fifo_pop = (state == RUN) && fifo_ready && !fifo_popped_last && (occupancy + in_flight - transfer) < 2.
  - fifo_pop is combinational from the inputs and registered state.
- Capture: when in_flight = 1, fifo_data is written into the buffer tail at the rising edge.
  - A capture and a transfer in the same cycle leave occupancy unchanged.
- The buffer is FIFO-ordered and never drops or duplicates a sample.
- Counters advance only on a transfer:
  - column increments.
  - At IMAGE_WIDTH-1, column wraps to 0 and row increments.
  - At (IMAGE_WIDTH-1, IMAGE_HEIGHT-1), both counters wrap to 0 and frame_done pulses in the next cycle.
- Markers are combinational from the counters and are qualified by pixel_valid. Downstream ignores them when pixel_valid = 0.
- When enable drops mid-frame, the counters are retained. On resume, the frame continues from the same position.

## Timing
- Reset values:
  - fifo_pop, pixel_valid, frame_done = 0.
  - column, row = 0; pixel_data = 0.
  - start_of_frame = 1; end_of_line, end_of_frame = 0.
  - State = IDLE; occupancy = 0; in_flight = 0.
- Reset mid-operation discards buffered and in-flight samples and clears the counters. Any FIFO data already popped is lost.
- Latency: fifo_pop high in cycle t, data captured at the end of t+1, pixel_valid high in t+2.
- Sustained throughput is 1 pixel/cycle when fifo_ready = 1 and pixel_ready = 1.
- Backpressure with pixel_ready = 0:
  - At most 2 samples are held.
  - fifo_pop stays low while occupancy + in_flight = 2.
  - pixel_data and the markers stay stable while pixel_valid = 1 and pixel_ready = 0.
- When fifo_popped_last = 1, no pop occurs that cycle, even if fifo_ready is stale-high.
- When fifo_ready is low, no pops occur. pixel_valid falls once the buffer empties.
- In DRAIN, fifo_pop = 0. Buffered pixels are still presented and transferred normally.

## Test plan
- Reset, then enable = 1, fifo_ready = 1, pixel_ready = 1, FIFO preloaded with 0x10, 0x11, 0x12 -> fifo_pop high at cycles 1-3, pixel_valid from cycle 3, pixel_data 0x10/0x11/0x12 at column 0/1/2, start_of_frame only on 0x10.
- Continuous stream with pixel_ready held low from the 2nd valid pixel -> fifo_pop stops after occupancy + in_flight = 2, pixel_data held at the 2nd pixel; release -> remaining samples delivered in order with no loss.
- IMAGE_WIDTH = 4, IMAGE_HEIGHT = 2, 8 samples -> end_of_line at columns 3 of rows 0 and 1, end_of_frame on the 8th pixel, frame_done pulse one cycle later, counters back to (0,0).
- FIFO holding 1 entry with fifo_popped_last asserted after the pop while fifo_ready glitches high -> exactly one pop, one pixel out.
- enable dropped after 5 pixels of a frame with 2 buffered -> state DRAIN, no pops, 2 pixels delivered, IDLE; re-enable -> next pixel at column 7.
- reset asserted with occupancy = 2 -> pixel_valid = 0 immediately, counters (0,0), state IDLE.

Source files
------------

// File: rtl/fifo_stream_reader.sv
// Pops pixels from the image FIFO into a valid/ready stream, hiding the FIFO's
// one-cycle read latency behind a 2-entry skid buffer and tagging each pixel's position.
module fifo_stream_reader #(
  parameter int unsigned DATA_WIDTH    = 8,
  parameter int unsigned IMAGE_WIDTH   = 640,
  parameter int unsigned IMAGE_HEIGHT  = 480,
  parameter int unsigned COUNTER_WIDTH = 16
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     enable,
  input  logic                     fifo_ready,
  input  logic [DATA_WIDTH-1:0]    fifo_data,
  input  logic                     fifo_popped_last,
  output logic                     fifo_pop,
  output logic [DATA_WIDTH-1:0]    pixel_data,
  output logic                     pixel_valid,
  input  logic                     pixel_ready,
  output logic [COUNTER_WIDTH-1:0] column,
  output logic [COUNTER_WIDTH-1:0] row,
  output logic                     start_of_frame,
  output logic                     end_of_line,
  output logic                     end_of_frame,
  output logic                     frame_done
);

  localparam logic [COUNTER_WIDTH-1:0] LAST_COL = COUNTER_WIDTH'(IMAGE_WIDTH - 1);
  localparam logic [COUNTER_WIDTH-1:0] LAST_ROW = COUNTER_WIDTH'(IMAGE_HEIGHT - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } state_t;

  state_t                  state_q;
  state_t                  state_d;
  logic [1:0]              occupancy;
  logic                    in_flight;
  logic [DATA_WIDTH-1:0]   skid_head;
  logic [DATA_WIDTH-1:0]   skid_tail;
  logic                    transfer;
  logic [2:0]              credits_after;
  logic                    last_col;
  logic                    last_row;

  always_comb begin
    pixel_valid    = (occupancy != 2'd0);
    pixel_data     = skid_head;
    transfer       = pixel_valid && pixel_ready;
    last_col       = (column == LAST_COL);
    last_row       = (row == LAST_ROW);
    start_of_frame = (column == '0) && (row == '0);
    end_of_line    = last_col;
    end_of_frame   = last_col && last_row;
  end

  // Credits count both buffered samples and the one still in the FIFO's read
  // pipeline, so a pop is only issued when a slot is guaranteed next cycle.
  always_comb begin
    credits_after = {1'b0, occupancy} + {2'b00, in_flight} - {2'b00, transfer};
    fifo_pop      = (state_q == RUN) && fifo_ready && !fifo_popped_last &&
                    (credits_after < 3'd2);
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (enable) state_d = RUN;
      RUN:     if (!enable) state_d = DRAIN;
      DRAIN: begin
        if (enable)
          state_d = RUN;
        else if ((occupancy == 2'd0) && !in_flight)
          state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset)
      state_q <= IDLE;
    else
      state_q <= state_d;
  end

  // Skid buffer: head is what's presented; the captured sample lands in the
  // first free slot after accounting for a same-cycle transfer out of head.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      occupancy <= 2'd0;
      in_flight <= 1'b0;
      skid_head <= '0;
      skid_tail <= '0;
    end else begin
      in_flight <= fifo_pop;
      occupancy <= occupancy + {1'b0, in_flight} - {1'b0, transfer};
      if (transfer) begin
        if (occupancy == 2'd2) begin
          skid_head <= skid_tail;
          if (in_flight)
            skid_tail <= fifo_data;
        end else if (in_flight) begin
          skid_head <= fifo_data;
        end
      end else if (in_flight) begin
        if (occupancy == 2'd0)
          skid_head <= fifo_data;
        else
          skid_tail <= fifo_data;
      end
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      column     <= '0;
      row        <= '0;
      frame_done <= 1'b0;
    end else begin
      frame_done <= transfer && last_col && last_row;
      if (transfer) begin
        if (last_col) begin
          column <= '0;
          row    <= last_row ? '0 : row + 1'b1;
        end else begin
          column <= column + 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_fifo_stream_reader.sv
// Directed bench for fifo_stream_reader with an 8x2 image and a behavioural
// FIFO with one-cycle read latency on the pop side.
module tb_fifo_stream_reader;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        enable = 1'b0;
  logic        fifo_ready;
  logic [7:0]  fifo_data = 8'h00;
  logic        fifo_popped_last = 1'b0;
  logic        fifo_pop;
  logic [7:0]  pixel_data;
  logic        pixel_valid;
  logic        pixel_ready = 1'b0;
  logic [15:0] column;
  logic [15:0] row;
  logic        start_of_frame;
  logic        end_of_line;
  logic        end_of_frame;
  logic        frame_done;

  int checks   = 0;
  int failures = 0;

  logic [7:0]  mem [64];
  int unsigned wr_ptr = 0;
  int unsigned rd_ptr = 0;
  int unsigned pop_count = 0;
  logic        force_ready = 1'b0;

  fifo_stream_reader #(
    .DATA_WIDTH(8),
    .IMAGE_WIDTH(8),
    .IMAGE_HEIGHT(2),
    .COUNTER_WIDTH(16)
  ) dut (
    .clock(clock),
    .reset(reset),
    .enable(enable),
    .fifo_ready(fifo_ready),
    .fifo_data(fifo_data),
    .fifo_popped_last(fifo_popped_last),
    .fifo_pop(fifo_pop),
    .pixel_data(pixel_data),
    .pixel_valid(pixel_valid),
    .pixel_ready(pixel_ready),
    .column(column),
    .row(row),
    .start_of_frame(start_of_frame),
    .end_of_line(end_of_line),
    .end_of_frame(end_of_frame),
    .frame_done(frame_done)
  );

  always #5 clock = ~clock;

  assign fifo_ready = ((wr_ptr - rd_ptr) != 0) || force_ready;

  always @(posedge clock) begin
    fifo_popped_last <= fifo_pop && ((wr_ptr - rd_ptr) == 1);
    if (fifo_pop) begin
      fifo_data <= mem[rd_ptr % 64];
      rd_ptr    <= rd_ptr + 1;
      pop_count <= pop_count + 1;
    end
  end

  task automatic cyc;
    @(posedge clock);
    #1;
  endtask

  task automatic settle;
    #1;
  endtask

  task automatic push(input logic [7:0] d);
    mem[wr_ptr % 64] = d;
    wr_ptr = wr_ptr + 1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_pix(input string tag, input logic [7:0] d, input int c, input int r);
    chk({tag, ".valid"}, 32'(pixel_valid), 32'd1);
    chk({tag, ".data"},  32'(pixel_data), 32'(d));
    chk({tag, ".col"},   32'(column), 32'(c));
    chk({tag, ".row"},   32'(row), 32'(r));
    chk({tag, ".sof"},   32'(start_of_frame), 32'((c == 0) && (r == 0)));
    chk({tag, ".eol"},   32'(end_of_line), 32'(c == 7));
    chk({tag, ".eof"},   32'(end_of_frame), 32'((c == 7) && (r == 1)));
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    #22 reset = 1'b1;

    // Reset values, then 3-sample latency and ordering
    cyc;
    enable = 1'b1; pixel_ready = 1'b1;
    push(8'h10); push(8'h11); push(8'h12);
    settle;
    chk("rst.pop", 32'(fifo_pop), 32'd0);
    chk("rst.valid", 32'(pixel_valid), 32'd0);
    chk("rst.data", 32'(pixel_data), 32'd0);
    chk("rst.col", 32'(column), 32'd0);
    chk("rst.row", 32'(row), 32'd0);
    chk("rst.sof", 32'(start_of_frame), 32'd1);
    chk("rst.eol", 32'(end_of_line), 32'd0);
    chk("rst.eof", 32'(end_of_frame), 32'd0);
    chk("rst.fdone", 32'(frame_done), 32'd0);
    chk("rst.state", 32'(dut.state_q), 32'd0);
    cyc; settle; chk("lat.pop1", 32'(fifo_pop), 32'd1);
    cyc; settle; chk("lat.pop2", 32'(fifo_pop), 32'd1);
    chk("lat.novalid", 32'(pixel_valid), 32'd0);
    cyc; settle; chk("lat.pop3", 32'(fifo_pop), 32'd1);
    chk_pix("lat.p0", 8'h10, 0, 0);
    cyc; settle; chk("lat.lastpop", 32'(fifo_pop), 32'd0);
    chk_pix("lat.p1", 8'h11, 1, 0);
    cyc; settle; chk_pix("lat.p2", 8'h12, 2, 0);

    // Backpressure from the second valid pixel
    cyc;
    for (int i = 0; i < 6; i++) push(8'(8'h20 + i));
    settle;
    chk("bp.empty", 32'(pixel_valid), 32'd0);
    chk("bp.pop0", 32'(fifo_pop), 32'd1);
    cyc; settle; chk("bp.pop1", 32'(fifo_pop), 32'd1);
    cyc; settle; chk_pix("bp.p20", 8'h20, 3, 0);
    chk("bp.pop2", 32'(fifo_pop), 32'd1);
    cyc; pixel_ready = 1'b0; settle;
    chk_pix("bp.p21", 8'h21, 4, 0);
    chk("bp.stall0", 32'(fifo_pop), 32'd0);
    for (int i = 0; i < 2; i++) begin
      cyc; settle;
      chk_pix("bp.hold", 8'h21, 4, 0);
      chk("bp.stall", 32'(fifo_pop), 32'd0);
    end
    cyc; pixel_ready = 1'b1; settle;
    chk_pix("bp.rel", 8'h21, 4, 0);
    chk("bp.resume", 32'(fifo_pop), 32'd1);
    for (int k = 1; k <= 4; k++) begin
      cyc; settle;
      chk_pix("bp.drain", 8'(8'h21 + k), (4 + k) % 8, (4 + k) / 8);
    end

    // Complete the frame: end_of_frame and frame_done
    cyc;
    for (int i = 0; i < 7; i++) push(8'(8'h30 + i));
    settle;
    chk("fr.empty", 32'(pixel_valid), 32'd0);
    cyc; settle;
    for (int k = 0; k < 7; k++) begin
      cyc; settle;
      chk_pix("fr.pix", 8'(8'h30 + k), 1 + k, 1);
    end
    cyc; settle;
    chk("fr.done", 32'(frame_done), 32'd1);
    chk("fr.valid", 32'(pixel_valid), 32'd0);
    chk("fr.col0", 32'(column), 32'd0);
    chk("fr.row0", 32'(row), 32'd0);
    chk("fr.sof", 32'(start_of_frame), 32'd1);

    // Single entry with stale fifo_ready after the last pop
    cyc; push(8'h40); settle;
    chk("fr.donepulse", 32'(frame_done), 32'd0);
    chk("last.pop", 32'(fifo_pop), 32'd1);
    cyc; force_ready = 1'b1; settle;
    chk("last.nopop", 32'(fifo_pop), 32'd0);
    cyc; force_ready = 1'b0; settle;
    chk_pix("last.pix", 8'h40, 0, 0);
    cyc; settle;
    chk("last.gone", 32'(pixel_valid), 32'd0);
    chk("last.popcnt", pop_count, 32'd17);

    // Reset with the buffer full
    cyc; pixel_ready = 1'b0; push(8'h50); push(8'h51); settle;
    chk("rf.pop0", 32'(fifo_pop), 32'd1);
    cyc; settle; chk("rf.pop1", 32'(fifo_pop), 32'd1);
    cyc; settle; chk("rf.full", 32'(fifo_pop), 32'd0);
    cyc; settle;
    chk_pix("rf.held", 8'h50, 1, 0);
    chk("rf.occ", 32'(dut.occupancy), 32'd2);
    #2 reset = 1'b0; enable = 1'b0;
    #1;
    chk("rf.valid", 32'(pixel_valid), 32'd0);
    chk("rf.col", 32'(column), 32'd0);
    chk("rf.row", 32'(row), 32'd0);
    chk("rf.sof", 32'(start_of_frame), 32'd1);
    chk("rf.state", 32'(dut.state_q), 32'd0);
    chk("rf.pop", 32'(fifo_pop), 32'd0);
    cyc; reset = 1'b1;

    // Drop enable after 5 pixels with 2 buffered, then resume
    cyc;
    enable = 1'b1; pixel_ready = 1'b1;
    for (int i = 0; i < 10; i++) push(8'(8'h60 + i));
    settle;
    chk("dr.idle", 32'(fifo_pop), 32'd0);
    cyc; settle; chk("dr.pop", 32'(fifo_pop), 32'd1);
    cyc; settle;
    for (int k = 0; k < 5; k++) begin
      cyc; settle;
      chk_pix("dr.pix", 8'(8'h60 + k), k, 0);
    end
    cyc; pixel_ready = 1'b0; settle;
    chk_pix("dr.hold", 8'h65, 5, 0);
    chk("dr.stall", 32'(fifo_pop), 32'd0);
    cyc; enable = 1'b0; settle;
    chk_pix("dr.hold2", 8'h65, 5, 0);
    cyc; pixel_ready = 1'b1; settle;
    chk("dr.state", 32'(dut.state_q), 32'd2);
    chk("dr.nopop", 32'(fifo_pop), 32'd0);
    chk_pix("dr.p65", 8'h65, 5, 0);
    cyc; settle;
    chk_pix("dr.p66", 8'h66, 6, 0);
    chk("dr.nopop2", 32'(fifo_pop), 32'd0);
    cyc; settle;
    chk("dr.empty", 32'(pixel_valid), 32'd0);
    cyc; settle;
    chk("dr.idle2", 32'(dut.state_q), 32'd0);
    enable = 1'b1;
    cyc; settle; chk("dr.repop", 32'(fifo_pop), 32'd1);
    cyc; settle;
    cyc; settle; chk_pix("dr.p67", 8'h67, 7, 0);
    cyc; settle; chk_pix("dr.p68", 8'h68, 0, 1);
    cyc; settle; chk_pix("dr.p69", 8'h69, 1, 1);
    cyc; settle;
    chk("dr.popcnt", pop_count, 32'd29);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
